pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer for the MIPS core; sits directly upstream of the 32-bit adder, which computes PC+4 from this block's PC.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents one instruction at a time to decode.
- Applies branch, jump and jump-register redirects, and squashes wrong-path fetches.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/pc_fetch_unit_adder.sv | 18 +
 rtl/pc_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: widths, fetch defaults and fetch-state encoding.
// Imported by the PC/fetch unit and its PC+4 adder.
package mips_pkg;

    localparam int ADDR_W = 32;
    localparam int JIDX_W = 26;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned       PC_STEP_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] word_align(
        input logic [ADDR_W-1:0] addr
    );
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_adder.sv
// Combinational adder producing the sequential PC (pc + step).
// Carry out is dropped so the result wraps modulo 2^W.
module pc_fetch_unit_adder
    import mips_pkg::*;
#(
    parameter int W = ADDR_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    // Modulo-2^W sum; 0xFFFF_FFFC + 4 wraps silently to zero
    always_comb begin
        sum = a + b;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer (IDLE -> REQ -> VALID).
// Optional build macro PC_FETCH_PERF_EN adds the perf_fetch_count output.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_count
`endif
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              vld_q, vld_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              redirect;
    logic [ADDR_W-1:0] raw_tgt;
    logic [ADDR_W-1:0] tgt;
    logic              accept;

    pc_fetch_unit_adder #(
        .W (ADDR_W)
    ) u_adder (
        .a   (pc_q),
        .b   (STEP),
        .sum (pc_plus4)
    );

    assign redirect = jr | jump | branch_taken;

    // Redirect target select, jr over jump over branch, word aligned
    always_comb begin
        raw_tgt = pc_q;
        unique case (1'b1)
            jr:
                raw_tgt = jr_target;
            (!jr && jump):
                raw_tgt = {pc_plus4[31:28], jump_index, 2'b00};
            (!jr && !jump && branch_taken):
                raw_tgt = branch_target;
            default:
                raw_tgt = pc_q;
        endcase
        tgt = word_align(raw_tgt);
    end

    // Next-state and datapath updates for the fetch sequencer
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        vld_d      = vld_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        accept     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = tgt;
                end
                state_d = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Fetch in flight is wrong-path; newest target wins
                        pc_d   = tgt;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = pend_tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        vld_d   = 1'b1;
                        state_d = VALID;
                        accept  = 1'b1;
                    end
                end else if (redirect) begin
                    // Address must stay stable until ack, so defer
                    pend_d     = 1'b1;
                    pend_tgt_d = tgt;
                end
            end
            VALID: begin
                if (redirect) begin
                    vld_d   = 1'b0;
                    pc_d    = tgt;
                    state_d = REQ;
                end else if (!stall) begin
                    vld_d   = 1'b0;
                    pc_d    = pc_plus4;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            vld_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            vld_q      <= vld_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = vld_q;

`ifdef PC_FETCH_PERF_EN
    logic [31:0] perf_q;

    // Count fetches whose data was delivered to decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_fetch_count = perf_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus random bench for pc_fetch_unit.
// Reference model tracks fetch progress as simple flags and a PC.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef PC_FETCH_PERF_EN
    logic [31:0] perf_fetch_count;
`endif

    pc_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4)
`ifdef PC_FETCH_PERF_EN
        ,
        .perf_fetch_count (perf_fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model
    logic [31:0] m_pc;
    logic        m_started;
    logic        m_busy;
    logic        m_have;
    logic [31:0] m_instr;
    logic        m_pend;
    logic [31:0] m_pend_tgt;
    logic [31:0] m_count;

    task automatic model_reset();
        m_pc = 32'h0; m_started = 1'b0; m_busy = 1'b0;
        m_have = 1'b0; m_instr = 32'h0; m_pend = 1'b0;
        m_pend_tgt = 32'h0; m_count = 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_busy});
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
        if (m_have) chk("instr", instr, m_instr);
        if (m_busy) chk("imem_addr", imem_addr, m_pc);
`ifdef PC_FETCH_PERF_EN
        chk("perf", perf_fetch_count, m_count);
`endif
    endtask

    // One clock: apply inputs, advance model, check after the edge
    task automatic cyc(input logic s, input logic br, input logic [31:0] bt,
                       input logic j, input logic [25:0] ji,
                       input logic r, input logic [31:0] rt,
                       input logic a);
        logic        redir;
        logic [31:0] t;
        logic [31:0] nxt;
        stall = s; branch_taken = br; branch_target = bt;
        jump = j; jump_index = ji; jr = r; jr_target = rt;
        imem_ack = a;
        imem_rdata = a ? (m_pc ^ 32'hA5A5_A5A5) : $urandom;
        redir = r | j | br;
        nxt = m_pc + 32'd4;
        if (r)      t = rt;
        else if (j) t = {nxt[31:28], ji, 2'b00};
        else        t = bt;
        t[1:0] = 2'b00;
        if (!m_started) begin
            if (redir) m_pc = t;
            m_started = 1'b1;
            m_busy = 1'b1;
        end else if (m_busy) begin
            if (a) begin
                if (redir) begin
                    m_pc = t; m_pend = 1'b0;
                end else if (m_pend) begin
                    m_pc = m_pend_tgt; m_pend = 1'b0;
                end else begin
                    m_instr = imem_rdata; m_have = 1'b1;
                    m_busy = 1'b0; m_count = m_count + 32'd1;
                end
            end else if (redir) begin
                m_pend = 1'b1; m_pend_tgt = t;
            end
        end else begin
            if (redir || !s) begin
                m_have = 1'b0;
                m_pc = redir ? t : nxt;
                m_busy = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_cyc(input logic s, input logic a);
        cyc(s, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, a);
    endtask

    initial begin
        logic [31:0] held_instr;
        stall = 0; branch_taken = 0; branch_target = 0;
        jump = 0; jump_index = 0; jr = 0; jr_target = 0;
        imem_ack = 0; imem_rdata = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        rst_n = 1;

        // Sequential fetch 0x0, 0x4, 0x8
        idle_cyc(0, 0);
        chk("seq_addr0", imem_addr, 32'h0);
        chk("seq_req0", {31'b0, imem_req}, 32'h1);
        idle_cyc(0, 1);
        chk("seq_instr0", instr, 32'hA5A5_A5A5);
        idle_cyc(0, 0);
        chk("seq_addr1", imem_addr, 32'h4);
        idle_cyc(0, 1);
        chk("seq_instr1", instr, 32'hA5A5_A5A1);
        idle_cyc(0, 0);
        chk("seq_addr2", imem_addr, 32'h8);
        idle_cyc(0, 1);
        chk("seq_valid2", {31'b0, instr_valid}, 32'h1);

        // Stall hold at pc 0x8
        held_instr = instr;
        for (int i = 0; i < 5; i++) begin
            idle_cyc(1, 0);
            chk("stall_instr", instr, held_instr);
            chk("stall_pc", pc, 32'h8);
        end
        idle_cyc(0, 0);
        chk("stall_release_addr", imem_addr, 32'hC);

        // Jump from 0x1000_0010
        cyc(0, 0, 0, 0, 0, 1, 32'h1000_0010, 1);
        idle_cyc(0, 1);
        chk("jmp_valid_before", {31'b0, instr_valid}, 32'h1);
        cyc(0, 0, 0, 1, 26'h0000040, 0, 0, 0);
        chk("jmp_valid_drop", {31'b0, instr_valid}, 32'h0);
        chk("jmp_addr", imem_addr, 32'h1000_0100);

        // Redirect during an outstanding fetch at 0x20
        cyc(0, 0, 0, 0, 0, 1, 32'h20, 1);
        chk("out_addr", imem_addr, 32'h20);
        cyc(0, 1, 32'h0000_0203, 0, 0, 0, 0, 0);
        chk("out_hold1", imem_addr, 32'h20);
        idle_cyc(0, 0);
        chk("out_hold2", imem_addr, 32'h20);
        idle_cyc(0, 1);
        chk("out_squash_valid", {31'b0, instr_valid}, 32'h0);
        chk("out_new_addr", imem_addr, 32'h200);

        // Priority on the ack cycle
        cyc(0, 1, 32'h800, 1, 26'h3, 1, 32'h400, 1);
        chk("prio_valid", {31'b0, instr_valid}, 32'h0);
        chk("prio_addr", imem_addr, 32'h400);

        // Wrap past the top of the address space
        cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        chk("wrap_p4", pc_plus4, 32'h0);
        idle_cyc(0, 1);
        idle_cyc(0, 0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 1) == 0,
                $urandom_range(0, 7) == 0, $urandom,
                $urandom_range(0, 9) == 0, 26'($urandom),
                $urandom_range(0, 11) == 0, $urandom,
                m_busy && ($urandom_range(0, 2) == 0));
        end

        // Reset asserted while a request is outstanding
        for (int k = 0; k < 20 && !m_busy; k++) idle_cyc(0, 0);
        chk("mid_req_before", {31'b0, imem_req}, 32'h1);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
        chk("mid_rst_pc", pc, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        idle_cyc(0, 0);
        chk("post_rst_addr", imem_addr, 32'h0);
        idle_cyc(0, 1);
        idle_cyc(0, 0);
        chk("post_rst_addr1", imem_addr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
